// File: rtl/galois_mult_arbiter.sv
// rtl/galois_mult_arbiter.sv - round-robin sharing of one pipelined Barrett modular multiplier
// Multiplier core first, then the arbiter that grants, tags and routes products back.

module galois_mult_barrett_sync #(
  parameter int                N_BITS        = 254,
  parameter logic [N_BITS-1:0] PRIME_MODULUS = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001,
  parameter logic [N_BITS:0]   BARRETT_R     = (N_BITS+1)'({1'b1, {(2*N_BITS){1'b0}}} / PRIME_MODULUS),
  parameter int                MULT_LATENCY  = 12
) (
  input  logic              clk,
  input  logic [N_BITS-1:0] num1_i,
  input  logic [N_BITS-1:0] num2_i,
  output logic [N_BITS-1:0] product_o
);
  localparam int W2 = 2 * N_BITS;
  localparam int WR = N_BITS + 2;
  localparam int ND = MULT_LATENCY - 3;

  logic [N_BITS-1:0] a_q, b_q;
  logic [W2-1:0]     x_q, x2_q;
  logic [N_BITS:0]   qt_q, qt_d;
  logic [WR-1:0]     r_q, r_d;
  logic [N_BITS-1:0] res_q [ND];
  logic [N_BITS-1:0] res_d;
  logic [W2+1:0]     qprod;
  logic [W2-1:0]     qp;
  logic [WR-1:0]     p1, p2;

  // Quotient estimate is at most 2 low, so the remainder lands in [0, 3p).
  always_comb begin
    qprod = (W2+2)'(x_q[W2-1:N_BITS-1]) * (W2+2)'(BARRETT_R);
    qt_d  = (N_BITS+1)'(qprod >> (N_BITS + 1));
    qp    = W2'(qt_q) * W2'(PRIME_MODULUS);
    r_d   = WR'(x2_q - qp);
    p1    = WR'(PRIME_MODULUS);
    p2    = p1 << 1;
    if (r_q >= p2) begin
      res_d = N_BITS'(r_q - p2);
    end else if (r_q >= p1) begin
      res_d = N_BITS'(r_q - p1);
    end else begin
      res_d = N_BITS'(r_q);
    end
  end

  always_ff @(posedge clk) begin
    a_q      <= num1_i;
    b_q      <= num2_i;
    x_q      <= W2'(a_q) * W2'(b_q);
    x2_q     <= x_q;
    qt_q     <= qt_d;
    r_q      <= r_d;
    res_q[0] <= res_d;
    for (int j = 1; j < ND; j++) begin
      res_q[j] <= res_q[j-1];
    end
  end

  assign product_o = res_q[ND-1];
endmodule

module galois_mult_arbiter #(
  parameter int                N_BITS        = 254,
  parameter logic [N_BITS-1:0] PRIME_MODULUS = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001,
  parameter logic [N_BITS:0]   BARRETT_R     = (N_BITS+1)'({1'b1, {(2*N_BITS){1'b0}}} / PRIME_MODULUS),
  parameter int                N_REQ         = 4,
  parameter int                MULT_LATENCY  = 12
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [N_REQ-1:0]                  req_valid,
  input  logic [N_REQ*N_BITS-1:0]           req_num1,
  input  logic [N_REQ*N_BITS-1:0]           req_num2,
  output logic [N_REQ-1:0]                  req_ready,
  input  logic                              hold,
  output logic [N_REQ-1:0]                  resp_valid,
  output logic [N_BITS-1:0]                 resp_product,
  output logic [$clog2(MULT_LATENCY+2)-1:0] in_flight,
  output logic                              idle
);
  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(MULT_LATENCY + 2);
  localparam int L  = MULT_LATENCY;

  logic [PW-1:0]         ptr_q, ptr_d;
  logic [L:0]            tag_v_q;
  logic [L:0][PW-1:0]    tag_id_q;
  logic [CW-1:0]         in_flight_q, in_flight_d;
  logic [N_REQ-1:0]      resp_valid_q, resp_valid_d;
  logic [N_BITS-1:0]     resp_product_q, resp_product_d;
  logic [N_REQ-1:0]      grant;
  logic [PW-1:0]         grant_id;
  logic [N_BITS-1:0]     op1, op2, mult_product;
  logic                  hs, retire;
  logic [PW-1:0]         ret_id;

  function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] p, input int off);
    return PW'((int'(p) + off) % N_REQ);
  endfunction

  // Scan from lowest priority to highest so the last hit is the winner.
  always_comb begin
    grant = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      if (!reset && !hold && req_valid[rr_idx(ptr_q, off)]) begin
        grant = N_REQ'(1) << rr_idx(ptr_q, off);
      end
    end
  end

  always_comb begin
    grant_id = '0;
    op1      = '0;
    op2      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        grant_id = PW'(i);
        op1      = req_num1[i*N_BITS +: N_BITS];
        op2      = req_num2[i*N_BITS +: N_BITS];
      end
    end
  end

  assign hs     = |grant;
  assign retire = tag_v_q[L];
  assign ret_id = tag_id_q[L];

  always_comb begin
    ptr_d          = hs ? grant_id : ptr_q;
    resp_valid_d   = retire ? (N_REQ'(1) << ret_id) : '0;
    resp_product_d = retire ? mult_product : resp_product_q;
    in_flight_d    = in_flight_q;
    if (hs && !retire) begin
      in_flight_d = in_flight_q + CW'(1);
    end else if (!hs && retire) begin
      in_flight_d = in_flight_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q          <= PW'(N_REQ - 1);
      tag_v_q        <= '0;
      in_flight_q    <= '0;
      resp_valid_q   <= '0;
      resp_product_q <= '0;
    end else begin
      ptr_q          <= ptr_d;
      tag_v_q        <= {tag_v_q[L-1:0], hs};
      in_flight_q    <= in_flight_d;
      resp_valid_q   <= resp_valid_d;
      resp_product_q <= resp_product_d;
    end
  end

  // Owner ids only matter alongside a valid bit, so they need no reset.
  always_ff @(posedge clk) begin
    tag_id_q <= {tag_id_q[L-1:0], grant_id};
  end

  galois_mult_barrett_sync #(
    .N_BITS        (N_BITS),
    .PRIME_MODULUS (PRIME_MODULUS),
    .BARRETT_R     (BARRETT_R),
    .MULT_LATENCY  (MULT_LATENCY)
  ) u_mult (
    .clk       (clk),
    .num1_i    (op1),
    .num2_i    (op2),
    .product_o (mult_product)
  );

  assign req_ready    = grant;
  assign resp_valid   = resp_valid_q;
  assign resp_product = resp_product_q;
  assign in_flight    = in_flight_q;
  assign idle         = (in_flight_q == '0) && !hs;
endmodule

// File: tb/tb_galois_mult_arbiter.sv
// tb/tb_galois_mult_arbiter.sv - randomized bench for galois_mult_arbiter against a queue-based model
// The model predicts grants by round-robin rule and products with plain modular arithmetic.

module tb_galois_mult_arbiter;
  localparam int NB  = 254;
  localparam int NR  = 4;
  localparam int LAT = 12;
  localparam logic [NB-1:0] P = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR-1:0]    req_valid;
  logic [NR*NB-1:0] req_num1, req_num2;
  logic [NR-1:0]    req_ready;
  logic             hold;
  logic [NR-1:0]    resp_valid;
  logic [NB-1:0]    resp_product;
  logic [3:0]       in_flight;
  logic             idle;

  always #5 clk = ~clk;

  galois_mult_arbiter #(.N_BITS(NB), .N_REQ(NR), .MULT_LATENCY(LAT)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_num1     (req_num1),
    .req_num2     (req_num2),
    .req_ready    (req_ready),
    .hold         (hold),
    .resp_valid   (resp_valid),
    .resp_product (resp_product),
    .in_flight    (in_flight),
    .idle         (idle)
  );

  typedef struct {
    int            due;
    int            id;
    logic [NB-1:0] prod;
  } resp_t;

  resp_t         exp_q[$];
  int            ptr_m;
  int            edge_n;
  logic [NR-1:0] g_m, g_prev;
  int            errors = 0;
  int            checks = 0;

  task automatic chk(input string tag, input logic [NB+1:0] obs, input logic [NB+1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NB-1:0] fe_rand();
    logic [255:0] r;
    int           s;
    s = $urandom_range(0, 7);
    for (int w = 0; w < 8; w++) r[w*32 +: 32] = $urandom;
    case (s)
      0:       return '0;
      1:       return P - 1;
      2:       return NB'(1);
      default: return NB'(r % 256'(P));
    endcase
  endfunction

  function automatic logic [NB-1:0] mod_mul(input logic [NB-1:0] a, input logic [NB-1:0] b);
    logic [2*NB-1:0] t;
    t = (2*NB)'(a) * (2*NB)'(b);
    t = t % (2*NB)'(P);
    return t[NB-1:0];
  endfunction

  function automatic logic [NR-1:0] model_grant();
    if (reset || hold) return '0;
    for (int off = 1; off <= NR; off++) begin
      int i;
      i = (ptr_m + off) % NR;
      if (req_valid[i]) return NR'(1) << i;
    end
    return '0;
  endfunction

  // Check outputs mid-cycle, then advance the model across the next rising edge.
  task automatic cycle();
    resp_t e;
    @(negedge clk);
    g_m = model_grant();
    chk("req_ready", req_ready, g_m);
    if (exp_q.size() > 0 && exp_q[0].due == edge_n) begin
      chk("resp_valid", resp_valid, NR'(1) << exp_q[0].id);
      chk("resp_product", resp_product, exp_q[0].prod);
      void'(exp_q.pop_front());
    end else begin
      chk("resp_valid_idle", resp_valid, '0);
    end
    chk("in_flight", in_flight, exp_q.size());
    chk("idle", idle, (exp_q.size() == 0 && g_m == '0));
    @(posedge clk);
    edge_n++;
    if (reset) begin
      exp_q.delete();
      ptr_m = NR - 1;
    end else if (g_m != '0) begin
      for (int i = 0; i < NR; i++) begin
        if (g_m[i]) begin
          e.id   = i;
          e.due  = edge_n + LAT + 1;
          e.prod = mod_mul(req_num1[i*NB +: NB], req_num2[i*NB +: NB]);
          exp_q.push_back(e);
          ptr_m = i;
        end
      end
    end
    g_prev = g_m;
    #1;
  endtask

  // Requesters keep their operands until granted.
  task automatic drive(input logic [NR-1:0] vpat, input logic h, input logic r);
    for (int i = 0; i < NR; i++) begin
      if (!req_valid[i] || g_prev[i]) begin
        req_num1[i*NB +: NB] = fe_rand();
        req_num2[i*NB +: NB] = fe_rand();
      end
    end
    req_valid = vpat;
    hold      = h;
    reset     = r;
  endtask

  task automatic run(input int n, input logic [NR-1:0] vpat, input logic h, input logic r);
    repeat (n) begin
      drive(vpat, h, r);
      cycle();
    end
  endtask

  initial begin
    reset     = 1'b1;
    hold      = 1'b0;
    req_valid = '0;
    req_num1  = '0;
    req_num2  = '0;
    g_prev    = '0;
    ptr_m     = NR - 1;
    edge_n    = 0;
    @(posedge clk);
    #1;
    edge_n = 1;

    // reset held with every requester valid: no grants
    run(3, '1, 1'b0, 1'b1);
    chk("reset_product", resp_product, '0);

    // single op from requester 1
    drive(4'b0010, 1'b0, 1'b0);
    req_num1[1*NB +: NB] = NB'(3);
    req_num2[1*NB +: NB] = NB'(5);
    cycle();
    run(15, '0, 1'b0, 1'b0);

    // wrap-around operands from requester 0
    drive(4'b0001, 1'b0, 1'b0);
    req_num1[0 +: NB] = P - 1;
    req_num2[0 +: NB] = P - 1;
    cycle();
    drive(4'b0001, 1'b0, 1'b0);
    req_num1[0 +: NB] = '0;
    cycle();
    run(15, '0, 1'b0, 1'b0);

    // contention, hold in the middle, then drain
    run(20, '1, 1'b0, 1'b0);
    run(5, '1, 1'b1, 1'b0);
    run(10, '1, 1'b0, 1'b0);
    run(15, '0, 1'b0, 1'b0);

    // fairness between requesters 0 and 2
    run(12, 4'b0101, 1'b0, 1'b0);
    run(15, '0, 1'b0, 1'b0);

    // reset mid-operation drops in-flight products
    run(3, 4'b0111, 1'b0, 1'b0);
    run(2, '0, 1'b0, 1'b0);
    run(1, '0, 1'b0, 1'b1);
    run(16, '0, 1'b0, 1'b0);
    run(1, '1, 1'b0, 1'b0);
    run(15, '0, 1'b0, 1'b0);

    // random traffic with occasional hold and reset
    repeat (300) begin
      drive(NR'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 63) == 0));
      cycle();
    end
    run(16, '0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
